// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: exception codes carried to writeback and the
// memory-stage state encoding.
package mips_pkg;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_OVF   = 2'd1;
    localparam logic [1:0] EXC_ALIGN = 2'd2;
    localparam logic [1:0] EXC_BUS   = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/mem_req_fsm.sv
// Data-memory request sequencer: owns the registered req/we/addr/wdata bus and the
// optional access watchdog (built only when MEM_TIMEOUT_EN is defined).
//
//   state     | meaning
//   ST_IDLE   | no access outstanding; a start launches the bus request
//   ST_ACCESS | request held on the bus until ack (or watchdog expiry)
module mem_req_fsm
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              start_we,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [DATA_W-1:0] start_wdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic              done,
    output logic              timeout,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata
);

    mem_state_t state, state_nxt;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT) + 1;
    logic [CNT_W-1:0] cnt;
`else
    localparam int timeout_len_unused = MEM_TIMEOUT;
`endif

    assign stall = (state == ST_ACCESS);

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // an ack arriving on the final watchdog cycle still completes normally
                if (dmem_ack) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = ST_IDLE;
                end
`endif
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= start_we;
                dmem_addr  <= start_addr;
                dmem_wdata <= start_wdata;
            end else if (done || timeout) begin
                dmem_req <= 1'b0;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            cnt <= '0;
        end else if (state == ST_ACCESS && !dmem_ack) begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: EX/MEM latch, word load/store over a req/ack bus, MEM/WB bundle
// with exception code. Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_overflow,
    input  logic              ex_ovf_trap,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_exc
);

    logic             mem_op, trap, misaligned, start;
    logic             done, timeout;
    logic [REG_W-1:0] lat_write_reg;
    logic             lat_reg_write, lat_is_load;

    assign mem_op     = ex_mem_read | ex_mem_write;
    assign trap       = ex_ovf_trap & ex_overflow;
    assign misaligned = mem_op & (ex_alu_result[1:0] != 2'b00);
    assign start      = ex_valid & ~stall & mem_op & ~trap & ~misaligned;

    mem_req_fsm #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_req_fsm (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_we    (ex_mem_write),
        .start_addr  (ADDR_W'(ex_alu_result)),
        .start_wdata (ex_store_data),
        .dmem_ack    (dmem_ack),
        .stall       (stall),
        .done        (done),
        .timeout     (timeout),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write_reg <= '0;
            lat_reg_write <= 1'b0;
            lat_is_load   <= 1'b0;
            wb_valid      <= 1'b0;
            wb_write_reg  <= '0;
            wb_reg_write  <= 1'b0;
            wb_data       <= '0;
            wb_exc        <= EXC_NONE;
        end else begin
            wb_valid     <= 1'b0;
            wb_write_reg <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
            wb_exc       <= EXC_NONE;
            if (stall) begin
                if (done) begin
                    wb_valid     <= 1'b1;
                    wb_write_reg <= lat_write_reg;
                    wb_reg_write <= lat_is_load & lat_reg_write;
                    wb_data      <= lat_is_load ? dmem_rdata : DATA_W'(dmem_addr);
                end else if (timeout) begin
                    wb_valid     <= 1'b1;
                    wb_write_reg <= lat_write_reg;
                    wb_exc       <= EXC_BUS;
                end
            end else if (ex_valid) begin
                if (trap) begin
                    wb_valid     <= 1'b1;
                    wb_write_reg <= ex_write_reg;
                    wb_data      <= ex_alu_result;
                    wb_exc       <= EXC_OVF;
                end else if (misaligned) begin
                    wb_valid     <= 1'b1;
                    wb_write_reg <= ex_write_reg;
                    wb_data      <= ex_alu_result;
                    wb_exc       <= EXC_ALIGN;
                end else if (mem_op) begin
                    // a store wins when both read and write are flagged
                    lat_write_reg <= ex_write_reg;
                    lat_reg_write <= ex_reg_write;
                    lat_is_load   <= ~ex_mem_write;
                end else begin
                    wb_valid     <= 1'b1;
                    wb_write_reg <= ex_write_reg;
                    wb_reg_write <= ex_reg_write;
                    wb_data      <= ex_alu_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; a negedge monitor checks every MEM/WB bundle
// against a scoreboard filled by the stimulus process.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_write_reg;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_overflow, ex_ovf_trap;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_data;
    logic [1:0]  wb_exc;

    typedef struct {
        logic [4:0]  wr;
        logic        rw;
        logic [31:0] data;
        logic [1:0]  exc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_overflow(ex_overflow),
        .ex_ovf_trap(ex_ovf_trap), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_write_reg(wb_write_reg),
        .wb_reg_write(wb_reg_write), .wb_data(wb_data), .wb_exc(wb_exc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_wb(input logic [4:0] wr, input logic rw, input logic [31:0] data,
                             input logic [1:0] exc);
        exp_t e;
        e.wr = wr; e.rw = rw; e.data = data; e.exc = exc;
        sb.push_back(e);
    endtask

    // Presents one EX bundle for a single accept edge, then returns #1 after that edge.
    task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wr,
                         input logic rw, input logic rd, input logic wrt, input logic ovf,
                         input logic trap);
        ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_write_reg = wr;
        ex_reg_write = rw; ex_mem_read = rd; ex_mem_write = wrt;
        ex_overflow = ovf; ex_ovf_trap = trap;
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_write_reg = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_overflow = 1'b0; ex_ovf_trap = 1'b0;
    endtask

    // Called in the first request cycle; acks `delay` cycles after the request rises.
    task automatic respond(input string name, input int delay, input logic [31:0] rdata,
                           input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        int stall_cnt = 0;
        int bus_bad = 0;
        for (int c = 0; c <= delay; c++) begin
            if (c == delay) begin
                dmem_ack = 1'b1; dmem_rdata = rdata;
            end
            if (stall) stall_cnt++;
            if (!dmem_req || dmem_addr !== addr || dmem_we !== we || dmem_wdata !== wdata)
                bus_bad++;
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0; dmem_rdata = '0;
        check({name, "_stall_cycles"}, stall_cnt, delay + 1);
        check({name, "_bus_stable"}, bus_bad, 0);
        check({name, "_stall_released"}, {31'd0, stall}, 0);
        check({name, "_req_dropped"}, {31'd0, dmem_req}, 0);
    endtask

    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected_valid", {31'd0, wb_valid}, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_exc", {30'd0, wb_exc}, {30'd0, mon_e.exc});
                check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.rw});
                if (mon_e.rw) check("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, mon_e.wr});
                if (mon_e.exc == 2'd0) check("wb_data", wb_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0; ex_write_reg = '0;
        ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_overflow = 1'b0; ex_ovf_trap = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {stall, dmem_req, dmem_we, wb_valid, wb_reg_write, wb_exc,
                                wb_write_reg}, 0);
        check("reset_buses", dmem_addr | dmem_wdata | wb_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through
        expect_wb(5'd8, 1'b1, 32'h10, 2'd0);
        issue(32'h10, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("alu_no_stall", {31'd0, stall}, 0);
        check("alu_no_req", {31'd0, dmem_req}, 0);
        @(posedge clk); #1;

        // Load with ack three cycles after request
        expect_wb(5'd9, 1'b1, 32'hDEADBEEF, 2'd0);
        issue(32'h100, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        respond("load", 3, 32'hDEADBEEF, 32'h100, 1'b0, 32'h0);
        @(posedge clk); #1;

        // Store acked in the request cycle
        expect_wb(5'd0, 1'b0, 32'h204, 2'd0);
        issue(32'h204, 32'h1234, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        respond("store", 0, 32'h0, 32'h204, 1'b1, 32'h1234);
        @(posedge clk); #1;

        // Read and write both flagged: store behaviour
        expect_wb(5'd4, 1'b0, 32'h308, 2'd0);
        issue(32'h308, 32'hCAFE, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        respond("rdwr", 1, 32'h5555, 32'h308, 1'b1, 32'hCAFE);

        // Misaligned load
        expect_wb(5'd2, 1'b0, 32'h0, 2'd2);
        issue(32'h102, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("align_no_req", {31'd0, dmem_req}, 0);
        check("align_no_stall", {31'd0, stall}, 0);

        // Overflow trap on ALU op, then trap outranking misalignment
        expect_wb(5'd3, 1'b0, 32'h0, 2'd1);
        issue(32'h7FFFFFFF, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_wb(5'd3, 1'b0, 32'h0, 2'd1);
        issue(32'h103, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("trap_no_req", {31'd0, dmem_req}, 0);

        // Overflow without trap enable is an ordinary ALU result
        expect_wb(5'd6, 1'b1, 32'h80000000, 2'd0);
        issue(32'h80000000, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;

        // Bubble and stray ack while idle produce nothing
        ex_alu_result = 32'h55; ex_mem_read = 1'b1; dmem_ack = 1'b1;
        @(posedge clk); #1;
        ex_alu_result = '0; ex_mem_read = 1'b0; dmem_ack = 1'b0;
        check("idle_ack_no_req", {30'd0, dmem_req, stall}, 0);
        check("idle_no_wb", {31'd0, wb_valid}, 0);

        // Reset two cycles into an access, ack one cycle later
        issue(32'h300, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
        check("rst_access_outputs", {stall, dmem_req, dmem_we, wb_valid, wb_reg_write, wb_exc}, 0);
        check("rst_access_addr", dmem_addr, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0; dmem_rdata = '0;
        check("rst_late_ack", {29'd0, stall, dmem_req, wb_valid}, 0);
        @(posedge clk); #1;

`ifdef MEM_TIMEOUT_EN
        begin
            int stall_cnt = 0;
            expect_wb(5'd3, 1'b0, 32'h0, 2'd3);
            issue(32'h400, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            for (int c = 0; c < 20 && stall; c++) begin
                stall_cnt++;
                @(posedge clk); #1;
            end
            check("timeout_stall_cycles", stall_cnt, 4);
            check("timeout_req_dropped", {31'd0, dmem_req}, 0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
